// File: rtl/ddr_cmd_encoder.sv
// ddr_cmd_encoder
//   Controller-side command/address encoder for a DDR1 SDRAM. Takes one
//   request per valid/ready handshake. For exactly one cycle it drives the
//   command pins, the packed address and the function code. It then holds off
//   new requests for the minimum spacing of that command. It also tracks which
//   banks are open and the programmed burst length, and it rejects illegal
//   requests by issuing a NOP and pulsing err.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_func                0 DESEL,1 NOP,2 ACT,3 RD,4 WR,5 BST,6 PRE,7 REF,8 MRS
//   req_ba/row/col/ap       bank, row (ACT), column (RD/WR),
//                           auto-precharge / all-banks flag
//   req_opmode/cl/bt/bl     mode register fields (MRS)
//   CSn,RASn,CASn,WEn       registered command pins
//   cmd_addr                registered packed address, bank at [15:14]
//   cmd_adf                 registered function code of the driven command
//   bank_open               per-bank open flags
//   err                     one-cycle pulse when an illegal request was consumed
module ddr_cmd_encoder #(
  parameter int CAPACITY   = 4,
  parameter int DATA_WIDTH = 2,
  parameter int T_RCD      = 3,
  parameter int T_RP       = 3,
  parameter int T_RFC      = 10,
  parameter int T_MRD      = 2,
  localparam int ROW_WIDTH = (CAPACITY == 1) ? 12 : ((CAPACITY == 4) ? 14 : 13),
  localparam int COL_WIDTH = ((CAPACITY <= 2) ? 12 : 13) - DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_func,
  input  logic [1:0]           req_ba,
  input  logic [ROW_WIDTH-1:0] req_row,
  input  logic [COL_WIDTH-1:0] req_col,
  input  logic                 req_ap,
  input  logic [6:0]           req_opmode,
  input  logic [2:0]           req_cl,
  input  logic                 req_bt,
  input  logic [2:0]           req_bl,
  output logic                 CSn,
  output logic                 RASn,
  output logic                 CASn,
  output logic                 WEn,
  output logic [15:0]          cmd_addr,
  output logic [3:0]           cmd_adf,
  output logic [3:0]           bank_open,
  output logic                 err
);

  localparam int CNT_W = 8;

  localparam logic [3:0] F_DESEL = 4'd0;
  localparam logic [3:0] F_NOP   = 4'd1;
  localparam logic [3:0] F_ACT   = 4'd2;
  localparam logic [3:0] F_RD    = 4'd3;
  localparam logic [3:0] F_WR    = 4'd4;
  localparam logic [3:0] F_BST   = 4'd5;
  localparam logic [3:0] F_PRE   = 4'd6;
  localparam logic [3:0] F_REF   = 4'd7;
  localparam logic [3:0] F_MRS   = 4'd8;

  // Pin vectors in {CS,RAS,CAS,WE} order
  localparam logic [3:0] PINS_DESEL = 4'b1111;
  localparam logic [3:0] PINS_NOP   = 4'b0111;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] burst_gap_reg, burst_gap_next;
  logic [3:0]       pins_reg, pins_next;
  logic [15:0]      addr_reg, addr_next;
  logic [3:0]       adf_reg, adf_next;
  logic [3:0]       bank_reg, bank_next;
  logic             err_reg, err_next;

  logic             accept;
  logic             illegal;
  logic [15:0]      addr_pack;
  logic [CNT_W-1:0] gap;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid & req_ready;

  assign {CSn, RASn, CASn, WEn} = pins_reg;
  assign cmd_addr  = addr_reg;
  assign cmd_adf   = adf_reg;
  assign bank_open = bank_reg;
  assign err       = err_reg;

  // Requests the memory would reject or misinterpret.
  always_comb begin
    illegal = 1'b0;
    case (req_func)
      F_ACT:        illegal = bank_reg[req_ba];
      F_RD, F_WR:   illegal = !bank_reg[req_ba];
      F_REF, F_MRS: illegal = |bank_reg;
      default:      illegal = (req_func > F_MRS);
    endcase
  end

  // Address packing. A10 is reserved for the auto-precharge/all-banks flag.
  // For wide column widths, the column bits above bit 9 skip over A10.
  always_comb begin
    addr_pack        = '0;
    addr_pack[15:14] = req_ba;
    case (req_func)
      F_ACT: addr_pack[ROW_WIDTH-1:0] = req_row;
      F_RD, F_WR: begin
        addr_pack[10] = req_ap;
        for (int i = 0; i < COL_WIDTH; i++) begin
          if (COL_WIDTH < 11 || i < 10) addr_pack[i] = req_col[i];
          else                          addr_pack[i+1] = req_col[i];
        end
      end
      F_PRE: addr_pack[10] = req_ap;
      F_MRS: begin
        addr_pack[13:7] = req_opmode;
        addr_pack[6:4]  = req_cl;
        addr_pack[3]    = req_bt;
        addr_pack[2:0]  = req_bl;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    burst_gap_next = burst_gap_reg;
    pins_next      = PINS_NOP;
    adf_next       = F_NOP;
    addr_next      = addr_reg;
    bank_next      = bank_reg;
    err_next       = 1'b0;
    gap            = CNT_W'(1);

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            // Consume the request, drive NOP, touch no state.
            err_next = 1'b1;
          end else begin
            adf_next  = req_func;
            addr_next = addr_pack;
            case (req_func)
              F_DESEL: pins_next = PINS_DESEL;
              F_NOP:   pins_next = PINS_NOP;
              F_ACT: begin
                pins_next         = 4'b0011;
                gap               = CNT_W'(T_RCD);
                bank_next[req_ba] = 1'b1;
              end
              F_RD, F_WR: begin
                pins_next = (req_func == F_RD) ? 4'b0101 : 4'b0100;
                gap       = burst_gap_reg;
                if (req_ap) bank_next[req_ba] = 1'b0;
              end
              F_BST: pins_next = 4'b0110;
              F_PRE: begin
                pins_next = 4'b0010;
                gap       = CNT_W'(T_RP);
                if (req_ap) bank_next = 4'b0000;
                else        bank_next[req_ba] = 1'b0;
              end
              F_REF: begin
                pins_next = 4'b0001;
                gap       = CNT_W'(T_RFC);
              end
              F_MRS: begin
                pins_next = 4'b0000;
                gap       = CNT_W'(T_MRD);
                // The data bus needs BL/2 cycles per burst. Reserved
                // burst-length codes keep the previous spacing.
                case (req_bl)
                  3'd1:    burst_gap_next = CNT_W'(1);
                  3'd2:    burst_gap_next = CNT_W'(2);
                  3'd3:    burst_gap_next = CNT_W'(4);
                  default: ;
                endcase
              end
              default: ;
            endcase
            if (gap > CNT_W'(1)) begin
              state_next = ST_WAIT;
              cnt_next   = gap - CNT_W'(1);
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      burst_gap_reg <= CNT_W'(2);
      pins_reg      <= PINS_DESEL;
      addr_reg      <= '0;
      adf_reg       <= F_DESEL;
      bank_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      burst_gap_reg <= burst_gap_next;
      pins_reg      <= pins_next;
      addr_reg      <= addr_next;
      adf_reg       <= adf_next;
      bank_reg      <= bank_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// Testbench for ddr_cmd_encoder (CAPACITY=4, DATA_WIDTH=2: row 14 bits, col 11 bits).
// The stimulus pushes the hand-computed output of each request into a queue.
// A monitor pops and compares that entry whenever the DUT presents a command
// or an error cycle. The stimulus itself checks the reset state and the
// ready-low spacing.
module tb_ddr_cmd_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_func = '0;
  logic [1:0]  req_ba = '0;
  logic [13:0] req_row = '0;
  logic [10:0] req_col = '0;
  logic        req_ap = 1'b0;
  logic [6:0]  req_opmode = '0;
  logic [2:0]  req_cl = '0;
  logic        req_bt = 1'b0;
  logic [2:0]  req_bl = '0;
  logic        CSn, RASn, CASn, WEn;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_adf;
  logic [3:0]  bank_open;
  logic        err;

  ddr_cmd_encoder #(
    .CAPACITY(4), .DATA_WIDTH(2), .T_RCD(3), .T_RP(3), .T_RFC(10), .T_MRD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .req_ap(req_ap), .req_opmode(req_opmode), .req_cl(req_cl), .req_bt(req_bt),
    .req_bl(req_bl),
    .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn),
    .cmd_addr(cmd_addr), .cmd_adf(cmd_adf), .bank_open(bank_open), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  pins;
    logic [15:0] addr;
    logic [3:0]  adf;
    logic [3:0]  bank;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_got, mon_exp;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;

  function automatic obs_t mk(input logic [3:0] p, input logic [15:0] a,
                              input logic [3:0] f, input logic [3:0] b, input logic e);
    obs_t o;
    o.pins = p; o.addr = a; o.adf = f; o.bank = b; o.err = e;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, req);
    end
  endtask

  // Monitor: any cycle that is not a plain idle NOP is a presented output.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon_got = {CSn, RASn, CASn, WEn, cmd_addr, cmd_adf, bank_open, err};
      if (err || mon_got.pins != 4'b0111 || cmd_adf != 4'd1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL monitor_unexpected: got pins=%b addr=%h adf=%0d bank=%b err=%b, expected no output",
                   mon_got.pins, mon_got.addr, mon_got.adf, mon_got.bank, mon_got.err);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL monitor_cmd: got pins=%b addr=%h adf=%0d bank=%b err=%b expected pins=%b addr=%h adf=%0d bank=%b err=%b",
                     mon_got.pins, mon_got.addr, mon_got.adf, mon_got.bank, mon_got.err,
                     mon_exp.pins, mon_exp.addr, mon_exp.adf, mon_exp.bank, mon_exp.err);
          end else begin
            $display("cmd pins=%b addr=%h adf=%0d bank=%b err=%b ok",
                     mon_got.pins, mon_got.addr, mon_got.adf, mon_got.bank, mon_got.err);
          end
        end
      end
    end
  end

  // Issue one request and push its expected output. When exp_low is not
  // negative, also count the cycles during which ready stays low afterwards.
  task automatic issue(input string name, input logic [3:0] f, input logic [1:0] ba,
                       input logic [13:0] row, input logic [10:0] col, input logic ap,
                       input logic [6:0] opm, input logic [2:0] cl, input logic bt,
                       input logic [2:0] bl, input obs_t e, input int exp_low);
    int guard;
    int low;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL %s_wait_ready: got ready=0 expected ready=1 within 100 cycles", name);
    end
    req_func = f; req_ba = ba; req_row = row; req_col = col; req_ap = ap;
    req_opmode = opm; req_cl = cl; req_bt = bt; req_bl = bl;
    req_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_low >= 0) begin
      low = 0;
      while (!req_ready && low < 100) begin
        low++;
        @(posedge clk); #1;
      end
      chk({name, "_ready_low"}, low, exp_low);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then release away from a clock edge
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pins", {CSn, RASn, CASn, WEn}, 4'b1111);
    chk("rst_addr", cmd_addr, 16'h0000);
    chk("rst_adf", cmd_adf, 4'd0);
    chk("rst_bank", bank_open, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    chk("idle_pins", {CSn, RASn, CASn, WEn}, 4'b0111);
    chk("idle_adf", cmd_adf, 4'd1);
    mon_en = 1'b1;

    // name        func  ba    row       col      ap    opm    cl    bt    bl    expected output                                        ready-low
    issue("act2",  4'd2, 2'd2, 14'h1ABC, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0011, 16'h9ABC, 4'd2, 4'b0100, 1'b0), 2);
    issue("rd2ap", 4'd3, 2'd2, 14'h0000, 11'h5A3, 1'b1, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0101, 16'h8DA3, 4'd3, 4'b0000, 1'b0), 1);
    issue("mrs8",  4'd8, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd2, 1'b0, 3'd3, mk(4'b0000, 16'h0023, 4'd8, 4'b0000, 1'b0), 1);
    issue("act1",  4'd2, 2'd1, 14'h0055, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0011, 16'h4055, 4'd2, 4'b0010, 1'b0), 2);
    issue("wr1",   4'd4, 2'd1, 14'h0000, 11'h7FF, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0100, 16'h4BFF, 4'd4, 4'b0010, 1'b0), 3);
    issue("rdcls", 4'd3, 2'd3, 14'h0000, 11'h001, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0111, 16'h4BFF, 4'd1, 4'b0010, 1'b1), 0);
    issue("refop", 4'd7, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0111, 16'h4BFF, 4'd1, 4'b0010, 1'b1), 0);
    issue("actop", 4'd2, 2'd1, 14'h0123, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0111, 16'h4BFF, 4'd1, 4'b0010, 1'b1), 0);
    issue("fbad",  4'd9, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0111, 16'h4BFF, 4'd1, 4'b0010, 1'b1), 0);
    issue("bst",   4'd5, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0110, 16'h0000, 4'd5, 4'b0010, 1'b0), 0);
    issue("preal", 4'd6, 2'd0, 14'h0000, 11'h000, 1'b1, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0010, 16'h0400, 4'd6, 4'b0000, 1'b0), 2);
    issue("act3",  4'd2, 2'd3, 14'h3FFF, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0011, 16'hFFFF, 4'd2, 4'b1000, 1'b0), 2);
    issue("pre3",  4'd6, 2'd3, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0010, 16'hC000, 4'd6, 4'b0000, 1'b0), 2);
    issue("mrsb2", 4'd8, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h7F, 3'd3, 1'b1, 3'd1, mk(4'b0000, 16'h3FB9, 4'd8, 4'b0000, 1'b0), 1);
    issue("act0",  4'd2, 2'd0, 14'h0001, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0011, 16'h0001, 4'd2, 4'b0001, 1'b0), 2);
    issue("rd0",   4'd3, 2'd0, 14'h0000, 11'h002, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0101, 16'h0002, 4'd3, 4'b0001, 1'b0), 0);
    issue("pre0",  4'd6, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0010, 16'h0000, 4'd6, 4'b0000, 1'b0), 2);
    issue("ref",   4'd7, 2'd0, 14'h0000, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0001, 16'h0000, 4'd7, 4'b0000, 1'b0), -1);

    // REF is now waiting. Confirm ready is low, then reset in the middle of the wait.
    chk("ref_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("ref_ready_low2", req_ready, 1'b0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_pins", {CSn, RASn, CASn, WEn}, 4'b1111);
    chk("midrst_adf", cmd_adf, 4'd0);
    chk("midrst_ready", req_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", req_ready, 1'b1);
    chk("postrst_pins", {CSn, RASn, CASn, WEn}, 4'b0111);
    mon_en = 1'b1;

    // After reset the burst spacing returns to BL4 (one ready-low cycle).
    issue("act0b", 4'd2, 2'd0, 14'h0010, 11'h000, 1'b0, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0011, 16'h0010, 4'd2, 4'b0001, 1'b0), 2);
    issue("rd0ap", 4'd3, 2'd0, 14'h0000, 11'h000, 1'b1, 7'h00, 3'd0, 1'b0, 3'd0, mk(4'b0101, 16'h0400, 4'd3, 4'b0000, 1'b0), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
